// File: rtl/vrased_rst_ctrl.sv
// vrased_rst_ctrl
//
// Reset sequencer for VRASED. Turns per-monitor violation requests into a
// registered system reset for the openMSP430 core, checks that the core
// re-enters the reset handler after release, and keeps sticky cause bits and
// a saturating event counter for post-mortem readout.
//
// Ports:
//   clk       - system clock
//   por       - asynchronous active-high reset
//   viol      - [6:0] level-sensitive violation requests, one bit per monitor
//   pc        - core program counter
//   cause_clr - single-cycle pulse clearing cause and viol_cnt
//   sys_rst   - registered reset to the core, active high
//   cause     - sticky cause bits; [6:0] mirror viol, [7] = boot timeout
//   viol_cnt  - saturating count of reset events
//   busy      - high whenever the sequencer is not idle
module vrased_rst_ctrl #(
    parameter logic [15:0] HOLD_CYCLES   = 16'd4,
    parameter logic [15:0] BOOT_TIMEOUT  = 16'd64,
    parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
    input  logic        clk,
    input  logic        por,
    input  logic [6:0]  viol,
    input  logic [15:0] pc,
    input  logic        cause_clr,
    output logic        sys_rst,
    output logic [7:0]  cause,
    output logic [7:0]  viol_cnt,
    output logic        busy
);

    // A zero parameter behaves like 1, so both load values bottom out at 0.
    localparam logic [15:0] HOLD_LOAD = (HOLD_CYCLES == 16'd0) ? 16'd0 : HOLD_CYCLES - 16'd1;
    localparam logic [15:0] BOOT_LOAD = (BOOT_TIMEOUT == 16'd0) ? 16'd0 : BOOT_TIMEOUT - 16'd1;

    typedef enum logic [1:0] {StIdle, StHold, StBoot} state_e;

    state_e      state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] btmr_q, btmr_d;
    logic [7:0]  cause_d;
    logic [7:0]  cnt_d;
    logic        sys_rst_d;
    logic        busy_d;

    logic        any_viol;
    logic [7:0]  set_bits;
    logic        count_evt;
    logic [7:0]  cnt_base;

    assign any_viol = |viol;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        btmr_d    = btmr_q;
        set_bits  = 8'h00;
        count_evt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_viol) begin
                    state_d   = StHold;
                    hcnt_d    = HOLD_LOAD;
                    set_bits  = {1'b0, viol};
                    count_evt = 1'b1;
                end
            end
            StHold: begin
                // Causes keep accumulating during the hold, but only the event
                // that started it is counted.
                set_bits = {1'b0, viol};
                if (hcnt_q != 16'd0) begin
                    hcnt_d = hcnt_q - 16'd1;
                end else if (any_viol) begin
                    hcnt_d = HOLD_LOAD;
                end else begin
                    state_d = StBoot;
                    btmr_d  = BOOT_LOAD;
                end
            end
            StBoot: begin
                // A new violation wins over a simultaneous handler match.
                if (any_viol) begin
                    state_d   = StHold;
                    hcnt_d    = HOLD_LOAD;
                    set_bits  = {1'b0, viol};
                    count_evt = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    state_d = StIdle;
                end else if (btmr_q == 16'd0) begin
                    state_d   = StHold;
                    hcnt_d    = HOLD_LOAD;
                    set_bits  = 8'h80;
                    count_evt = 1'b1;
                end else begin
                    btmr_d = btmr_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A clear in the same cycle as a set keeps only this cycle's contribution.
        cause_d  = cause_clr ? set_bits : (cause | set_bits);
        cnt_base = cause_clr ? 8'h00 : viol_cnt;
        if (count_evt && (cnt_base != 8'hFF)) begin
            cnt_d = cnt_base + 8'd1;
        end else begin
            cnt_d = cnt_base;
        end

        sys_rst_d = (state_d == StHold);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge por) begin
        if (por) begin
            state_q  <= StIdle;
            hcnt_q   <= 16'd0;
            btmr_q   <= 16'd0;
            cause    <= 8'h00;
            viol_cnt <= 8'h00;
            sys_rst  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            btmr_q   <= btmr_d;
            cause    <= cause_d;
            viol_cnt <= cnt_d;
            sys_rst  <= sys_rst_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// Testbench for vrased_rst_ctrl: directed scenarios, a cycle-level reference
// model compared on every falling edge, and literal expectations per scenario.
module tb_vrased_rst_ctrl;

    localparam int HOLD = 4;
    localparam int BOOT = 64;
    localparam logic [15:0] RH = 16'h0000;
    localparam logic [15:0] PC_AWAY = 16'hE000;

    logic        clk = 1'b0;
    logic        por;
    logic [6:0]  viol;
    logic [15:0] pc;
    logic        cause_clr;
    logic        sys_rst;
    logic [7:0]  cause;
    logic [7:0]  viol_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    vrased_rst_ctrl dut (
        .clk       (clk),
        .por       (por),
        .viol      (viol),
        .pc        (pc),
        .cause_clr (cause_clr),
        .sys_rst   (sys_rst),
        .cause     (cause),
        .viol_cnt  (viol_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 resetting, 2 awaiting boot.
    // left = reset cycles still to be driven (including the current one),
    // elapsed = boot-window cycles already spent.
    typedef struct {
        int         mode;
        int         left;
        int         elapsed;
        logic [7:0] cause;
        int         cnt;
    } model_t;

    model_t m = '{mode: 0, left: 0, elapsed: 0, cause: 8'h00, cnt: 0};

    function automatic model_t step(model_t s, logic [6:0] v, logic [15:0] p, logic clr);
        model_t     n = s;
        logic [7:0] set = 8'h00;
        bit         ev = 1'b0;
        if (s.mode == 0) begin
            if (v != 0) begin n.mode = 1; n.left = HOLD; set = {1'b0, v}; ev = 1'b1; end
        end else if (s.mode == 1) begin
            set = {1'b0, v};
            if (s.left > 1) n.left = s.left - 1;
            else if (v != 0) n.left = HOLD;
            else begin n.mode = 2; n.elapsed = 0; end
        end else begin
            if (v != 0) begin
                n.mode = 1; n.left = HOLD; set = {1'b0, v}; ev = 1'b1;
            end else if (p == RH) begin
                n.mode = 0;
            end else if (s.elapsed >= BOOT - 1) begin
                n.mode = 1; n.left = HOLD; set = 8'h80; ev = 1'b1;
            end else begin
                n.elapsed = s.elapsed + 1;
            end
        end
        if (clr) begin
            n.cause = set;
            n.cnt   = ev ? 1 : 0;
        end else begin
            n.cause = s.cause | set;
            n.cnt   = (ev && s.cnt < 255) ? s.cnt + 1 : s.cnt;
        end
        return n;
    endfunction

    always @(posedge clk or posedge por) begin
        if (por) m <= '{mode: 0, left: 0, elapsed: 0, cause: 8'h00, cnt: 0};
        else     m <= step(m, viol, pc, cause_clr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_sys_rst", {31'd0, sys_rst}, {31'd0, m.mode == 1});
        chk("cyc_busy", {31'd0, busy}, {31'd0, m.mode != 0});
        chk("cyc_cause", {24'd0, cause}, {24'd0, m.cause});
        chk("cyc_viol_cnt", {24'd0, viol_cnt}, m.cnt);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_boot;
        int n = 0;
        while (sys_rst && n < 100) begin tick(); n++; end
    endtask

    task automatic clear_pulse;
        cause_clr = 1'b1; tick(); cause_clr = 1'b0;
    endtask

    task automatic go_idle;
        pc = RH; tick(); pc = PC_AWAY;
    endtask

    initial begin
        int hi;
        int n;
        por = 1'b1; viol = 7'h00; pc = PC_AWAY; cause_clr = 1'b0;
        repeat (3) tick();
        chk("por_sys_rst", {31'd0, sys_rst}, 32'd0);
        chk("por_busy", {31'd0, busy}, 32'd0);
        chk("por_cause", {24'd0, cause}, 32'd0);
        chk("por_cnt", {24'd0, viol_cnt}, 32'd0);
        por = 1'b0;
        tick();

        // Single one-cycle violation, handler reached two cycles after release.
        viol = 7'h01; tick(); viol = 7'h00;
        hi = 0;
        while (sys_rst && hi < 100) begin hi++; tick(); end
        chk("single_hold_len", hi, 32'd4);
        chk("single_cause", {24'd0, cause}, 32'h01);
        chk("single_cnt", {24'd0, viol_cnt}, 32'd1);
        tick();
        go_idle();
        chk("single_busy_after", {31'd0, busy}, 32'd0);

        // Violation held for six cycles extends the hold once.
        clear_pulse();
        hi = 0;
        viol = 7'h20;
        for (int i = 0; i < 6; i++) begin tick(); if (sys_rst) hi++; end
        viol = 7'h00;
        n = 0;
        while (n < 100) begin tick(); n++; if (sys_rst) hi++; else break; end
        chk("ext_hold_len", hi, 32'd8);
        chk("ext_cause", {24'd0, cause}, 32'h20);
        chk("ext_cnt", {24'd0, viol_cnt}, 32'd1);
        go_idle();

        // Boot timeout: pc never reaches the handler.
        clear_pulse();
        viol = 7'h01; tick(); viol = 7'h00;
        wait_boot();
        n = 0;
        while (!sys_rst && n < 200) begin tick(); n++; end
        chk("timeout_len", n, 32'd64);
        chk("timeout_cause", {24'd0, cause}, 32'h81);
        chk("timeout_cnt", {24'd0, viol_cnt}, 32'd2);
        wait_boot();
        go_idle();

        // Violation during boot beats a simultaneous handler match.
        clear_pulse();
        viol = 7'h01; tick(); viol = 7'h00;
        wait_boot();
        viol = 7'h40; pc = RH; tick(); viol = 7'h00; pc = PC_AWAY;
        chk("prio_sys_rst", {31'd0, sys_rst}, 32'd1);
        chk("prio_cause", {24'd0, cause}, 32'h41);
        chk("prio_cnt", {24'd0, viol_cnt}, 32'd2);
        wait_boot();
        go_idle();

        // Clear colliding with an idle violation, then saturation.
        cause_clr = 1'b1; viol = 7'h04; tick(); cause_clr = 1'b0; viol = 7'h00;
        chk("clr_cause", {24'd0, cause}, 32'h04);
        chk("clr_cnt", {24'd0, viol_cnt}, 32'd1);
        wait_boot();
        for (int i = 0; i < 300; i++) begin
            viol = 7'h01; tick(); viol = 7'h00;
            repeat (4) tick();
        end
        chk("sat_cnt", {24'd0, viol_cnt}, 32'hFF);
        go_idle();

        // Asynchronous reset while the hold is active.
        viol = 7'h01; tick(); viol = 7'h00;
        tick();
        chk("async_pre_rst", {31'd0, sys_rst}, 32'd1);
        #1 por = 1'b1;
        #1;
        chk("async_sys_rst", {31'd0, sys_rst}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_cause", {24'd0, cause}, 32'd0);
        chk("async_cnt", {24'd0, viol_cnt}, 32'd0);
        tick(); tick();
        por = 1'b0;
        tick();
        chk("release_busy", {31'd0, busy}, 32'd0);
        viol = 7'h02; tick(); viol = 7'h00;
        chk("release_sys_rst", {31'd0, sys_rst}, 32'd1);
        chk("release_cause", {24'd0, cause}, 32'h02);
        chk("release_cnt", {24'd0, viol_cnt}, 32'd1);
        wait_boot();
        go_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
